// File: rtl/bf_exec_if.sv
// Handshake and tape-RAM bundle between fetch, the execute stage, the tape RAM and the byte I/O.
// slave: the execute stage. master: its environment (fetch, RAM, I/O).
interface bf_exec_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PTR_W  = 16
);
    logic [15:0]       ins_in;
    logic              ins_valid;
    logic              ins_ready;
    logic [DATA_W-1:0] val_in;
    logic [DATA_W-1:0] val_out;
    logic              wb_en;
    logic [PTR_W-1:0]  ptr_select;
    logic [PTR_W-1:0]  ptr_wb;
    logic [15:0]       branch_val;
    logic              branch_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              busy;

    modport slave (
        input  ins_in, ins_valid, val_in, out_ready, in_data, in_valid,
        output ins_ready, val_out, wb_en, ptr_select, ptr_wb, branch_val, branch_en,
               out_data, out_valid, in_ready, busy
    );

    modport master (
        output ins_in, ins_valid, val_in, out_ready, in_data, in_valid,
        input  ins_ready, val_out, wb_en, ptr_select, ptr_wb, branch_val, branch_en,
               out_data, out_valid, in_ready, busy
    );
endinterface

// File: rtl/bf_exec_unit.sv
// Execute stage of the tape-machine core: cell add/sub, pointer move, BRZ/BRNZ, byte I/O.
// Define ALU_SAT_EN to make PLUS/MINUS saturate instead of wrapping.
module bf_exec_unit #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PTR_W  = 16,
    parameter int unsigned ADDR_W = 12
) (
    input logic      clk,
    input logic      rst,
    bf_exec_if.slave bus
);

    typedef enum logic [1:0] {StEmpty, StExec, StIoWait} state_e;

    typedef enum logic [3:0] {
        OpNop   = 4'd0,
        OpPlus  = 4'd1,
        OpMinus = 4'd2,
        OpInc   = 4'd3,
        OpDec   = 4'd4,
        OpBrz   = 4'd5,
        OpBrnz  = 4'd6,
        OpOut   = 4'd7,
        OpIn    = 4'd8
    } op_e;

    state_e            state_q, state_d;
    logic [15:0]       ins_q, ins_d;
    logic [DATA_W-1:0] val_q, val_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;

    logic              valid_q;
    logic              completes;
    logic              accept;
    logic [PTR_W-1:0]  nptr;
    logic [11:0]       amt12;
    logic [DATA_W-1:0] amt_d;
    logic [PTR_W-1:0]  amt_p;
    logic [DATA_W:0]   add_w;
    logic [DATA_W:0]   sub_w;
    logic [DATA_W-1:0] plus_res;
    logic [DATA_W-1:0] minus_res;
    logic [3:0]        op;

    assign valid_q = (state_q != StEmpty);
    assign op      = ins_q[15:12];

    // A zero immediate means "by one".
    assign amt12 = (ins_q[11:0] == 12'd0) ? 12'd1 : ins_q[11:0];
    assign amt_d = DATA_W'(amt12);
    assign amt_p = PTR_W'(amt12);

    assign add_w = {1'b0, val_q} + {1'b0, amt_d};
    assign sub_w = {1'b0, val_q} - {1'b0, amt_d};

`ifdef ALU_SAT_EN
    assign plus_res  = add_w[DATA_W] ? {DATA_W{1'b1}} : add_w[DATA_W-1:0];
    assign minus_res = sub_w[DATA_W] ? {DATA_W{1'b0}} : sub_w[DATA_W-1:0];
`else
    assign plus_res  = add_w[DATA_W-1:0];
    assign minus_res = sub_w[DATA_W-1:0];
`endif

    always_comb begin
        bus.val_out    = '0;
        bus.wb_en      = 1'b0;
        bus.branch_val = '0;
        bus.branch_en  = 1'b0;
        bus.out_data   = '0;
        bus.out_valid  = 1'b0;
        bus.in_ready   = 1'b0;
        nptr           = ptr_q;
        completes      = 1'b0;
        if (valid_q) begin
            case (op)
                OpPlus: begin
                    completes   = 1'b1;
                    bus.wb_en   = 1'b1;
                    bus.val_out = plus_res;
                end
                OpMinus: begin
                    completes   = 1'b1;
                    bus.wb_en   = 1'b1;
                    bus.val_out = minus_res;
                end
                OpInc: begin
                    completes = 1'b1;
                    nptr      = ptr_q + amt_p;
                end
                OpDec: begin
                    completes = 1'b1;
                    nptr      = ptr_q - amt_p;
                end
                OpBrz, OpBrnz: begin
                    completes = 1'b1;
                    // Branch test uses the latched stage value, never live val_in.
                    if ((val_q == '0) == (op == OpBrz)) begin
                        bus.branch_en  = 1'b1;
                        bus.branch_val = 16'(ins_q[ADDR_W-1:0]);
                    end
                end
                OpOut: begin
                    bus.out_valid = 1'b1;
                    bus.out_data  = val_q;
                    completes     = bus.out_ready;
                end
                OpIn: begin
                    bus.in_ready = 1'b1;
                    if (bus.in_valid) begin
                        completes   = 1'b1;
                        bus.wb_en   = 1'b1;
                        bus.val_out = bus.in_data;
                    end
                end
                default: completes = 1'b1;
            endcase
        end
    end

    assign bus.ins_ready  = !valid_q || (completes && !bus.branch_en);
    assign accept         = bus.ins_valid && bus.ins_ready;
    assign bus.ptr_select = nptr;
    assign bus.ptr_wb     = ptr_q;
    assign bus.busy       = valid_q;

    always_comb begin
        ins_d   = ins_q;
        val_d   = val_q;
        ptr_d   = completes ? nptr : ptr_q;
        state_d = state_q;
        if (accept) begin
            ins_d = bus.ins_in;
            // Forward our own write-back; the RAM read would still show the stale cell.
            val_d = bus.wb_en ? bus.val_out : bus.val_in;
        end
        unique case (state_q)
            StEmpty: if (accept) state_d = StExec;
            StExec, StIoWait: begin
                if (completes)    state_d = accept ? StExec : StEmpty;
                else              state_d = StIoWait;
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
            ins_q   <= '0;
            val_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            val_q   <= val_d;
            ptr_q   <= ptr_d;
        end
    end

endmodule

// File: tb/tb_bf_exec_unit.sv
// Directed bench for bf_exec_unit: ALU, pointer, branch, OUT stall with mid-wait reset, IN.
module tb_bf_exec_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bf_exec_if #(.DATA_W(16), .PTR_W(16)) bus ();

    bf_exec_unit #(.DATA_W(16), .PTR_W(16), .ADDR_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ins_in    = 16'h0;
        bus.ins_valid = 1'b0;
        bus.val_in    = 16'h0;
        bus.out_ready = 1'b0;
        bus.in_data   = 16'h0;
        bus.in_valid  = 1'b0;
        #1;
        check("rst_ins_ready", 32'(bus.ins_ready), 32'd1);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_wb_en", 32'(bus.wb_en), 32'd0);
        check("rst_ptr_select", 32'(bus.ptr_select), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        #20;
        rst = 1'b0;
        tick();

        // PLUS imm0 on cell 5
        bus.ins_in = 16'h1000; bus.ins_valid = 1'b1; bus.val_in = 16'h0005;
        tick();
        bus.ins_valid = 1'b0; #1;
        check("plus1_wb_en", 32'(bus.wb_en), 32'd1);
        check("plus1_val_out", 32'(bus.val_out), 32'h0006);
        check("plus1_ptr_wb", 32'(bus.ptr_wb), 32'h0);
        tick();

        // PLUS imm3 twice back-to-back, second forwarded
        bus.ins_in = 16'h1003; bus.ins_valid = 1'b1; bus.val_in = 16'h0;
        tick();
        check("plus3a_val_out", 32'(bus.val_out), 32'h0003);
        check("plus3a_ins_ready", 32'(bus.ins_ready), 32'd1);
        tick();
        bus.ins_valid = 1'b0; #1;
        check("plus3b_fwd", 32'(bus.val_out), 32'h0006);
        tick();

        // DEC imm0 then INC imm2
        bus.ins_in = 16'h4000; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
        check("dec_ptr_select", 32'(bus.ptr_select), 32'hFFFF);
        check("dec_wb_en", 32'(bus.wb_en), 32'd0);
        tick();
        bus.ins_in = 16'h3002; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
        check("inc_ptr_wb", 32'(bus.ptr_wb), 32'hFFFF);
        check("inc_ptr_select", 32'(bus.ptr_select), 32'h0001);
        tick();

        // BRZ / BRNZ on zero and non-zero cells
        bus.ins_in = 16'h5123; bus.val_in = 16'h0; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
        check("brz0_en", 32'(bus.branch_en), 32'd1);
        check("brz0_val", 32'(bus.branch_val), 32'h0123);
        check("brz0_ins_ready", 32'(bus.ins_ready), 32'd0);
        tick();
        bus.ins_in = 16'h5123; bus.val_in = 16'h1; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; bus.val_in = 16'h0; #1;
        check("brz1_en", 32'(bus.branch_en), 32'd0);
        check("brz1_ins_ready", 32'(bus.ins_ready), 32'd1);
        tick();
        bus.ins_in = 16'h6123; bus.val_in = 16'h1; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
        check("brnz1_en", 32'(bus.branch_en), 32'd1);
        check("brnz1_val", 32'(bus.branch_val), 32'h0123);
        tick();
        bus.ins_in = 16'h6123; bus.val_in = 16'h0; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; bus.val_in = 16'h1; #1;
        check("brnz0_en", 32'(bus.branch_en), 32'd0);
        tick();

        // OUT with out_ready low for 3 cycles and a NOP waiting behind it
        bus.ins_in = 16'h7000; bus.val_in = 16'h0041; bus.ins_valid = 1'b1;
        tick();
        bus.ins_in = 16'h0000; bus.val_in = 16'h0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("out_wait_valid", 32'(bus.out_valid), 32'd1);
            check("out_wait_data", 32'(bus.out_data), 32'h0041);
            check("out_wait_ins_ready", 32'(bus.ins_ready), 32'd0);
            tick();
        end
        bus.out_ready = 1'b1; #1;
        check("out_fire_valid", 32'(bus.out_valid), 32'd1);
        check("out_fire_ins_ready", 32'(bus.ins_ready), 32'd1);
        tick();
        bus.out_ready = 1'b0; bus.ins_valid = 1'b0; #1;
        check("out_done_valid", 32'(bus.out_valid), 32'd0);
        check("out_done_busy", 32'(bus.busy), 32'd1);
        tick();

        // Reset in the middle of an OUT wait
        bus.ins_in = 16'h7000; bus.val_in = 16'h0041; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
        check("out2_valid", 32'(bus.out_valid), 32'd1);
        check("out2_ptr_wb", 32'(bus.ptr_wb), 32'h0001);
        rst = 1'b1; #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_out_data", 32'(bus.out_data), 32'h0);
        check("midrst_ins_ready", 32'(bus.ins_ready), 32'd1);
        check("midrst_ptr_select", 32'(bus.ptr_select), 32'h0);
        #2; rst = 1'b0;
        tick();

        // MINUS imm0 on cell 0, PLUS imm2 on cell 0xFFFF
        bus.ins_in = 16'h2000; bus.val_in = 16'h0; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
`ifdef ALU_SAT_EN
        check("minus_floor", 32'(bus.val_out), 32'h0000);
`else
        check("minus_wrap", 32'(bus.val_out), 32'hFFFF);
`endif
        tick();
        bus.ins_in = 16'h1002; bus.val_in = 16'hFFFF; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
`ifdef ALU_SAT_EN
        check("plus_ceil", 32'(bus.val_out), 32'hFFFF);
`else
        check("plus_wrap", 32'(bus.val_out), 32'h0001);
`endif
        tick();

        // IN: stall one cycle, then data arrives
        bus.ins_in = 16'h8000; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
        check("in_wait_ready", 32'(bus.in_ready), 32'd1);
        check("in_wait_wb_en", 32'(bus.wb_en), 32'd0);
        check("in_wait_ins_ready", 32'(bus.ins_ready), 32'd0);
        tick();
        bus.in_data = 16'h0007; bus.in_valid = 1'b1; #1;
        check("in_wb_en", 32'(bus.wb_en), 32'd1);
        check("in_val_out", 32'(bus.val_out), 32'h0007);
        check("in_ins_ready", 32'(bus.ins_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0; #1;
        check("in_done_busy", 32'(bus.busy), 32'd0);

        // Opcode 9 behaves as NOP
        bus.ins_in = 16'h9ABC; bus.ins_valid = 1'b1;
        tick();
        bus.ins_valid = 1'b0; #1;
        check("nop9_wb_en", 32'(bus.wb_en), 32'd0);
        check("nop9_ptr_select", 32'(bus.ptr_select), 32'h0);
        check("nop9_ins_ready", 32'(bus.ins_ready), 32'd1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
